// File: rtl/decomp_pkg.sv
// decomp_pkg: decode state enum, token flag encodings and default widths for the decompressor.
// Defining DECOMP_PARITY_EN adds the PARITY state.
package decomp_pkg;
    localparam int PIX_W = 8;
    localparam int CNT_W = 4;
    localparam int RUN_MAX = 2**CNT_W;
    localparam logic FLAG_LIT = 1'b1;
    localparam logic FLAG_RUN = 1'b0;
`ifdef DECOMP_PARITY_EN
    typedef enum logic [1:0] {FLAG, DATA, COUNT, PARITY} state_t;
`else
    typedef enum logic [1:0] {FLAG, DATA, COUNT} state_t;
`endif
endpackage

// File: rtl/sclk_sync.sv
// sclk_sync: synchronizes SCLK_in/OB_in into the CLK_8 domain and flags each SCLK rising edge.
module sclk_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sclk_i,
    input  logic ob_i,
    output logic bit_rise_o,
    output logic bit_val_o
);
    logic [SYNC_STAGES-1:0] sclk_q, ob_q;
    logic prev_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sclk_q <= '0;
            ob_q   <= '0;
            prev_q <= 1'b0;
        end else begin
            sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk_i};
            ob_q   <= {ob_q[SYNC_STAGES-2:0], ob_i};
            prev_q <= sclk_q[SYNC_STAGES-1];
        end
    end
    assign bit_rise_o = sclk_q[SYNC_STAGES-1] & ~prev_q;
    assign bit_val_o  = ob_q[SYNC_STAGES-1];
endmodule

// File: rtl/decompressor.sv
// decompressor: decodes the serial run-length token stream (OB_in/SCLK_in) into pixel pulses.
// Optional DECOMP_PARITY_EN: each token carries a trailing even-parity bit.
module decompressor
    import decomp_pkg::*;
#(
    parameter int PIX_W       = decomp_pkg::PIX_W,
    parameter int CNT_W       = decomp_pkg::CNT_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK_8,
    input  logic             Reset,
    input  logic             OB_in,
    input  logic             SCLK_in,
    output logic [PIX_W-1:0] Pixel_out,
    output logic             Pixel_valid,
    output logic             Err
);
    localparam int CW = $clog2(PIX_W);
    localparam logic [CW-1:0] LAST_D = CW'(PIX_W - 1);
    localparam logic [CW-1:0] LAST_C = CW'(CNT_W - 1);

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [PIX_W-1:0] shift_q, shift_d, last_pix_q, pix_q, payload;
    logic [CNT_W-1:0] run_left_q;
    logic             valid_q, err_q, bit_rise, bit_val, tok_lit, tok_run, par_err;

    sclk_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_i(CLK_8), .rst_ni(Reset), .sclk_i(SCLK_in), .ob_i(OB_in),
        .bit_rise_o(bit_rise), .bit_val_o(bit_val)
    );

    assign shift_d = {shift_q[PIX_W-2:0], bit_val};

`ifdef DECOMP_PARITY_EN
    localparam state_t TAIL = PARITY;
    logic par_q, lit_q, at_tail, par_ok;
    assign at_tail = bit_rise && state_q == PARITY;
    assign par_ok  = ~(par_q ^ bit_val);
    assign tok_lit = at_tail && lit_q && par_ok;
    assign tok_run = at_tail && !lit_q && par_ok;
    assign par_err = at_tail && !par_ok;
    assign payload = shift_q;
`else
    localparam state_t TAIL = FLAG;
    assign tok_lit = bit_rise && state_q == DATA && cnt_q == LAST_D;
    assign tok_run = bit_rise && state_q == COUNT && cnt_q == LAST_C;
    assign par_err = 1'b0;
    assign payload = shift_d;
`endif

    always_ff @(posedge CLK_8 or negedge Reset) begin
        if (!Reset) begin
            state_q    <= FLAG;
            cnt_q      <= '0;
            shift_q    <= '0;
            last_pix_q <= '0;
            pix_q      <= '0;
            run_left_q <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
`ifdef DECOMP_PARITY_EN
            par_q      <= 1'b0;
            lit_q      <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            if (bit_rise) begin
                cnt_q   <= cnt_q + 1'b1;
                shift_q <= shift_d;
                case (state_q)
                    FLAG: begin
                        state_q <= (bit_val == FLAG_LIT) ? DATA : COUNT;
                        cnt_q   <= '0;
                    end
                    DATA:    if (cnt_q == LAST_D) state_q <= TAIL;
                    COUNT:   if (cnt_q == LAST_C) state_q <= TAIL;
                    default: state_q <= FLAG;
                endcase
`ifdef DECOMP_PARITY_EN
                par_q <= (state_q == FLAG) ? bit_val : par_q ^ bit_val;
                if (state_q == FLAG) lit_q <= bit_val == FLAG_LIT;
`endif
            end
            // A completing token pre-empts any run still in progress; run_left counts pulses still owed.
            if (tok_lit || tok_run) begin
                valid_q    <= 1'b1;
                pix_q      <= tok_lit ? payload : last_pix_q;
                run_left_q <= tok_lit ? '0 : payload[CNT_W-1:0];
                if (tok_lit) last_pix_q <= payload;
                if (run_left_q != '0) err_q <= 1'b1;
            end else if (run_left_q != '0) begin
                valid_q    <= 1'b1;
                pix_q      <= last_pix_q;
                run_left_q <= run_left_q - 1'b1;
            end
            if (par_err) err_q <= 1'b1;
        end
    end

    assign Pixel_out   = pix_q;
    assign Pixel_valid = valid_q;
    assign Err         = err_q;
endmodule
